// File: rtl/sys_trace_pkg.sv
// Shared definitions for the trace-capture unit.
//   state_e : FSM state encoding, visible on the top-level state port
//   TS_W    : timestamp width stored per entry when SYS_TRACE_TIMESTAMP_EN is defined
//   ptr_w() : pointer width for a given buffer depth
package sys_trace_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StArmed = 3'd1,
    StPost  = 3'd2,
    StDone  = 3'd3,
    StRead  = 3'd4
  } state_e;

  localparam int unsigned TS_W = 16;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/sys_trace_ram.sv
// Register-array storage for the trace buffer.
//   clk_i   : write clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address (asynchronous read)
//   rdata_o : read data
// Contents are intentionally not reset; validity is tracked by the owner.
module sys_trace_ram #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sys_trace_buffer.sv
// Triggerable trace-capture unit. Records one word per enabled cycle into a circular
// buffer, freezes POST_TRIG entries after the first non-zero exception code, then
// streams the frozen window out oldest-first over a valid/ready port.
//   SYS_clk, SYS_reset_n : clock, asynchronous active-low reset
//   arm, abort           : start capture (IDLE only) / return to IDLE from anywhere
//   cap_en, cap_data     : capture qualifier and word
//   cap_exc              : exception code, non-zero marks the trigger
//   start_read           : begin readout (DONE only)
//   rd_ready/rd_valid/rd_data/rd_last : readout stream
//   state, trig_code, fill : status
// Optional: define SYS_TRACE_TIMESTAMP_EN to store a 16-bit free-running cycle count
// with every entry and present it on rd_ts alongside rd_data.
module sys_trace_buffer
  import sys_trace_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned EXC_W     = 3,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned POST_TRIG = 8
) (
  input  logic                     SYS_clk,
  input  logic                     SYS_reset_n,
  input  logic                     arm,
  input  logic                     abort,
  input  logic                     cap_en,
  input  logic [DATA_W-1:0]        cap_data,
  input  logic [EXC_W-1:0]         cap_exc,
  input  logic                     start_read,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_last,
  output logic [2:0]               state,
  output logic [EXC_W-1:0]         trig_code,
  output logic [$clog2(DEPTH):0]   fill
`ifdef SYS_TRACE_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]          rd_ts
`endif
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FillMax  = CW'(DEPTH);
  localparam logic [CW-1:0] PostTrig = CW'(POST_TRIG);

`ifdef SYS_TRACE_TIMESTAMP_EN
  localparam int unsigned RW = DATA_W + TS_W;
`else
  localparam int unsigned RW = DATA_W;
`endif

  state_e            state_q, state_d;
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     fill_q, fill_d;
  logic [CW-1:0]     post_q, post_d;
  logic [CW-1:0]     remain_q, remain_d;
  logic [EXC_W-1:0]  trig_q, trig_d;
  logic              wr_en;
  logic [RW-1:0]     wr_word;
  logic [RW-1:0]     rd_word;

`ifdef SYS_TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  // Free-running; wraps naturally at 0xFFFF.
  always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
    end
  end

  assign wr_word = {ts_q, cap_data};
`else
  assign wr_word = cap_data;
`endif

  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    fill_d   = fill_q;
    post_d   = post_q;
    remain_d = remain_q;
    trig_d   = trig_q;
    wr_en    = 1'b0;

    if (abort) begin
      state_d = StIdle;
      fill_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (arm) begin
            state_d = StArmed;
            fill_d  = '0;
            wptr_d  = '0;
            trig_d  = '0;
          end
        end
        StArmed, StPost: begin
          if (cap_en) begin
            wr_en  = 1'b1;
            wptr_d = wptr_q + PW'(1);
            if (fill_q != FillMax) begin
              fill_d = fill_q + CW'(1);
            end
            if (state_q == StArmed) begin
              if (cap_exc != '0) begin
                trig_d  = cap_exc;
                post_d  = '0;
                state_d = (PostTrig == '0) ? StDone : StPost;
              end
            end else begin
              // Later exceptions are ignored; only captures are counted.
              post_d = post_q + CW'(1);
              if (post_d == PostTrig) begin
                state_d = StDone;
              end
            end
          end
        end
        StDone: begin
          if (start_read) begin
            state_d  = StRead;
            // Oldest entry: fill==DEPTH wraps to wptr itself.
            rptr_d   = wptr_q - fill_q[PW-1:0];
            remain_d = fill_q;
          end
        end
        StRead: begin
          if (rd_ready) begin
            rptr_d   = rptr_q + PW'(1);
            remain_d = remain_q - CW'(1);
            if (remain_q == CW'(1)) begin
              state_d = StIdle;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      state_q  <= StIdle;
      wptr_q   <= '0;
      rptr_q   <= '0;
      fill_q   <= '0;
      post_q   <= '0;
      remain_q <= '0;
      trig_q   <= '0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      fill_q   <= fill_d;
      post_q   <= post_d;
      remain_q <= remain_d;
      trig_q   <= trig_d;
    end
  end

  sys_trace_ram #(
    .WIDTH (RW),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_ram (
    .clk_i   (SYS_clk),
    .we_i    (wr_en),
    .waddr_i (wptr_q),
    .wdata_i (wr_word),
    .raddr_i (rptr_q),
    .rdata_o (rd_word)
  );

  // Outputs decode from registered state only, so they are zero in reset and
  // stay stable while the consumer stalls.
  assign rd_valid  = (state_q == StRead);
  assign rd_last   = rd_valid && (remain_q == CW'(1));
  assign rd_data   = rd_valid ? rd_word[DATA_W-1:0] : '0;
  assign state     = state_q;
  assign trig_code = trig_q;
  assign fill      = fill_q;

`ifdef SYS_TRACE_TIMESTAMP_EN
  assign rd_ts = rd_valid ? rd_word[DATA_W +: TS_W] : '0;
`endif

endmodule

// File: tb/tb_sys_trace_buffer.sv
module tb_sys_trace_buffer;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned EXC_W     = 3;
  localparam int unsigned DEPTH     = 16;
  localparam int unsigned POST_TRIG = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              arm, abort, cap_en, start_read, rd_ready;
  logic [DATA_W-1:0] cap_data;
  logic [EXC_W-1:0]  cap_exc;
  logic              rd_valid, rd_last;
  logic [DATA_W-1:0] rd_data;
  logic [2:0]        state;
  logic [EXC_W-1:0]  trig_code;
  logic [4:0]        fill;
`ifdef SYS_TRACE_TIMESTAMP_EN
  logic [15:0]       rd_ts;
`endif

  always #5 clk = ~clk;

  sys_trace_buffer #(
    .DATA_W    (DATA_W),
    .EXC_W     (EXC_W),
    .DEPTH     (DEPTH),
    .POST_TRIG (POST_TRIG)
  ) dut (
    .SYS_clk     (clk),
    .SYS_reset_n (rst_n),
    .arm         (arm),
    .abort       (abort),
    .cap_en      (cap_en),
    .cap_data    (cap_data),
    .cap_exc     (cap_exc),
    .start_read  (start_read),
    .rd_ready    (rd_ready),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .rd_last     (rd_last),
    .state       (state),
    .trig_code   (trig_code),
    .fill        (fill)
`ifdef SYS_TRACE_TIMESTAMP_EN
    ,
    .rd_ts       (rd_ts)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Reference model: the captured history as a queue of {timestamp, word}.
  int               m_state;
  int               m_post;
  logic [EXC_W-1:0] m_trig;
  logic [47:0]      m_q[$];
  logic [47:0]      m_rd[$];
  logic [15:0]      cyc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= '0;
    else        cyc <= cyc + 16'd1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("state", 64'(state), 64'(m_state));
    chk("fill", 64'(fill), 64'(m_q.size()));
    chk("trig_code", 64'(trig_code), 64'(m_trig));
    chk("rd_valid", 64'(rd_valid), 64'(m_state == 4));
    if (m_state == 4) begin
      chk("rd_data", 64'(rd_data), 64'(m_rd[0][31:0]));
      chk("rd_last", 64'(rd_last), 64'(m_rd.size() == 1));
`ifdef SYS_TRACE_TIMESTAMP_EN
      chk("rd_ts", 64'(rd_ts), 64'(m_rd[0][47:32]));
`endif
    end
  endtask

  // One clock: update the model from the spec rules, clock the DUT, compare.
  task automatic step(input logic a, input logic ab, input logic en, input logic [31:0] d,
                      input logic [2:0] e, input logic sr, input logic rdy);
    logic [47:0] w;
    arm = a; abort = ab; cap_en = en; cap_data = d; cap_exc = e;
    start_read = sr; rd_ready = rdy;
    w = {cyc, d};
    if (ab) begin
      m_state = 0;
      m_q.delete();
    end else begin
      case (m_state)
        0: if (a) begin m_state = 1; m_q.delete(); m_trig = '0; end
        1, 2: if (en) begin
          m_q.push_back(w);
          if (m_q.size() > DEPTH) void'(m_q.pop_front());
          if (m_state == 1) begin
            if (e != 0) begin
              m_trig = e; m_post = 0;
              m_state = (POST_TRIG == 0) ? 3 : 2;
            end
          end else begin
            m_post++;
            if (m_post == POST_TRIG) m_state = 3;
          end
        end
        3: if (sr) begin m_state = 4; m_rd = m_q; end
        4: if (rdy) begin
          void'(m_rd.pop_front());
          if (m_rd.size() == 0) m_state = 0;
        end
        default: m_state = 0;
      endcase
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cap(input logic [31:0] d, input logic [2:0] e);
    step(0, 0, 1, d, e, 0, 0);
  endtask

  task automatic read_all(input int pattern);
    logic rdy;
    step(0, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 200 && m_state == 4; k++) begin
      case (pattern)
        0: rdy = 1'b1;
        1: rdy = ((k % 4) == 0) || ((k % 4) == 3);
        default: rdy = 1'($urandom);
      endcase
      step(0, 0, 0, 0, 0, 0, rdy);
    end
  endtask

  initial begin
    arm = 0; abort = 0; cap_en = 0; cap_data = '0; cap_exc = '0;
    start_read = 0; rd_ready = 0;
    m_state = 0; m_post = 0; m_trig = '0;
    #12;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    // Wrapped window with a late exception in POST that must be ignored.
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cap(32'h100 + 32'(i), 3'd0);
    cap(32'h114, 3'b010);
    for (int i = 0; i < 8; i++) cap(32'h115 + 32'(i), (i == 2) ? 3'd4 : 3'd0);
    read_all(1);
    idle();

    // Short window with capture gaps during POST.
    step(1, 0, 0, 0, 0, 0, 0);
    cap(32'h200, 3'd0);
    cap(32'h201, 3'd0);
    cap(32'h202, 3'd1);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 32'hdead, 3'd5, 0, 0);
      cap(32'h203 + 32'(i), 3'd0);
    end
    read_all(0);

    // Abort together with arm while in POST.
    step(1, 0, 0, 0, 0, 0, 0);
    cap(32'h300, 3'd2);
    cap(32'h301, 3'd0);
    step(1, 1, 1, 32'h302, 3'd0, 0, 0);
    idle();

    // Randomised captures and readouts.
    for (int r = 0; r < 4; r++) begin
      step(1, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 300 && m_state != 3; k++)
        step(0, 0, ($urandom % 4) != 0, $urandom,
             (($urandom % 8) == 0) ? 3'($urandom_range(1, 7)) : 3'd0, 0, 0);
      read_all(2);
      idle();
    end

    // Asynchronous reset in the middle of a readout.
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) cap(32'h400 + 32'(i), (i == 0) ? 3'd3 : 3'd0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_fill", 64'(fill), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_rd_last", 64'(rd_last), 64'd0);
    chk("rst_trig", 64'(trig_code), 64'd0);
    m_state = 0; m_q.delete(); m_rd.delete(); m_trig = '0;
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    step(1, 0, 0, 0, 0, 0, 0);
    cap(32'h500, 3'd0);
    cap(32'h501, 3'd6);
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
